// File: rtl/stream_pkg.sv
// Shared stream types and sizing helpers for the skid and FIFO stages.
package stream_pkg;

  localparam int STREAM_DATA_WIDTH = 32;

  // Depth 1 would give $clog2 = 0; keep at least one address bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic                         vld;
    logic [STREAM_DATA_WIDTH-1:0] dat;
  } stream_beat_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owner tracks which entries hold valid data.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO; in_ready decodes registers only (never out_ready).
// Define STREAM_FIFO_BYPASS_EN for a 0-cycle combinational pass-through while empty.
module stream_fifo
  import stream_pkg::*;
#(
  parameter  int DATA_WIDTH = STREAM_DATA_WIDTH,
  parameter  int DEPTH      = 4,
  parameter  int AF_MARGIN  = 1,
  localparam int ADDR_W     = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_W:0]       count,
  output logic                  almost_full
);

  localparam int               PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      count_d;
  logic                  almost_full_q;
  logic                  empty, full;
  logic                  push, pop, bypass;
  logic                  wr_en, rd_en;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign in_ready = ~full & ~rst;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

`ifdef STREAM_FIFO_BYPASS_EN
  // While empty the head is the incoming beat; if it is consumed now it is never stored.
  assign bypass    = empty & in_valid & out_ready & ~flush;
  assign out_valid = empty ? (in_valid & ~flush) : 1'b1;
  assign out_data  = empty ? in_data : ram_rdata;
`else
  assign bypass    = 1'b0;
  assign out_valid = ~empty;
  assign out_data  = ram_rdata;
`endif

  assign wr_en = push & ~bypass & ~flush;
  assign rd_en = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Modular pointer difference is the occupancy; the flag is registered off the next value.
  assign count_d = wr_ptr_d - rd_ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      almost_full_q <= (count_d >= AF_THR);
    end
  end

  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = almost_full_q;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo with a queue-based reference model checked every cycle.
module tb_stream_fifo;

  localparam int DW        = 32;
  localparam int DEPTH     = 4;
  localparam int AF_MARGIN = 1;
`ifdef STREAM_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    count;
  logic          almost_full;

  int errors = 0;
  int checks = 0;

  stream_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AF_MARGIN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of stored beats plus the registered flag.
  logic [DW-1:0] mq[$];
  bit            af_m = 1'b0;
  int            m_sz;
  bit            m_push, m_pop, m_byp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      af_m = 1'b0;
    end else begin
      m_sz   = mq.size();
      m_push = in_valid && (m_sz < DEPTH);
      m_byp  = BYP && (m_sz == 0) && in_valid && out_ready && !flush;
      m_pop  = (m_sz > 0) && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push && !m_byp) mq.push_back(in_data);
      end
      af_m = (mq.size() >= DEPTH - AF_MARGIN);
    end
  end

  always @(negedge clk) begin
    bit            exp_vld;
    logic [DW-1:0] exp_dat;
    exp_vld = (mq.size() > 0) || (BYP && in_valid && !flush && !rst);
    exp_dat = (mq.size() > 0) ? mq[0] : in_data;
    chk("cyc_in_ready",  {31'd0, in_ready},  {31'd0, (!rst && mq.size() < DEPTH)});
    chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
    chk("cyc_count",     {29'd0, count},     32'(mq.size()));
    chk("cyc_af",        {31'd0, almost_full}, {31'd0, af_m});
    if (exp_vld) chk("cyc_out_data", out_data, exp_dat);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid  = 1'b1;
      in_data   = base + 32'(i);
      out_ready = 1'b0;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] exp_seq [4];

  initial begin
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cyc(); cyc();
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();

    // Reset mid-stream with three entries held.
    fill(32'h10, 3);
    chk("pre_rst_count", {29'd0, count}, 32'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_count", {29'd0, count}, 32'd0);
    chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("async_rst_rdy", {31'd0, in_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    cyc();

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'hA0 + 32'(i); out_ready = 1'b0;
      cyc();
      chk("fill_count", {29'd0, count}, 32'(i + 1));
      chk("fill_af", {31'd0, almost_full}, (i + 1 >= 3) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    chk("fill_full_rdy", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_vld", {31'd0, out_valid}, 32'd1);
      chk("drain_data", out_data, 32'hA0 + 32'(i));
      cyc();
    end
    out_ready = 1'b0;
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // Full with simultaneous pop: no push-through.
    fill(32'hB0, 4);
    in_valid = 1'b1; in_data = 32'hC0; out_ready = 1'b1;
    #1;
    chk("fullpop_rdy", {31'd0, in_ready}, 32'd0);
    cyc();
    chk("fullpop_count", {29'd0, count}, 32'd3);
    out_ready = 1'b0;
    #1;
    chk("fullpop_rdy_next", {31'd0, in_ready}, 32'd1);
    chk("fullpop_head", out_data, 32'hB1);
    cyc();
    chk("fullpop_refill", {29'd0, count}, 32'd4);
    in_valid = 1'b0;
    exp_seq = '{32'hB1, 32'hB2, 32'hB3, 32'hC0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fullpop_order", out_data, exp_seq[i]);
      cyc();
    end
    out_ready = 1'b0;

    // Streaming with one preloaded beat.
    fill(32'h100, 1);
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i); out_ready = 1'b1;
      #1;
      chk("stream_data", out_data, 32'h100 + 32'(i - 1));
      chk("stream_count", {29'd0, count}, 32'd1);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    chk("stream_drained", {29'd0, count}, 32'd0);

    // Flush at count=2 with a push and pop pending.
    fill(32'hE0, 2);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hE2; out_ready = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_vld", {31'd0, out_valid}, 32'd0);
    cyc();

    // Empty FIFO, beat offered with downstream ready.
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    #1;
`ifdef STREAM_FIFO_BYPASS_EN
    chk("byp_vld", {31'd0, out_valid}, 32'd1);
    chk("byp_data", out_data, 32'h55);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("byp_count", {29'd0, count}, 32'd0);
    chk("byp_after_vld", {31'd0, out_valid}, 32'd0);
`else
    chk("nobyp_vld", {31'd0, out_valid}, 32'd0);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("nobyp_vld_next", {31'd0, out_valid}, 32'd1);
    chk("nobyp_data", out_data, 32'h55);
    chk("nobyp_count", {29'd0, count}, 32'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
`endif
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
